// File: rtl/rf_access_arbiter_if.sv
// Channel-side and RF-side handshake bundle for rf_access_arbiter.
// The arbiter takes the slave view; the surrounding masters/RF model take the master view.
interface rf_access_arbiter_if #(
    parameter int NUM_CH        = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int HMC_RF_AWIDTH = 4
);
    logic [NUM_CH-1:0]               ch_read_en;
    logic [NUM_CH-1:0]               ch_write_en;
    logic [NUM_CH*HMC_RF_AWIDTH-1:0] ch_address;
    logic [NUM_CH*HMC_RF_WWIDTH-1:0] ch_write_data;
    logic [NUM_CH-1:0]               ch_grant;
    logic [NUM_CH-1:0]               ch_done;
    logic [HMC_RF_RWIDTH-1:0]        ch_read_data;
    logic                            ch_invalid;
    logic                            ch_timeout;
    logic                            busy;
    logic [HMC_RF_WWIDTH-1:0]        rf_write_data;
    logic [HMC_RF_RWIDTH-1:0]        rf_read_data;
    logic [HMC_RF_AWIDTH-1:0]        rf_address;
    logic                            rf_read_en;
    logic                            rf_write_en;
    logic                            rf_invalid_address;
    logic                            rf_access_complete;

    modport slave (
        input  ch_read_en, ch_write_en, ch_address, ch_write_data,
        input  rf_read_data, rf_invalid_address, rf_access_complete,
        output ch_grant, ch_done, ch_read_data, ch_invalid, ch_timeout, busy,
        output rf_write_data, rf_address, rf_read_en, rf_write_en
    );

    modport master (
        output ch_read_en, ch_write_en, ch_address, ch_write_data,
        output rf_read_data, rf_invalid_address, rf_access_complete,
        input  ch_grant, ch_done, ch_read_data, ch_invalid, ch_timeout, busy,
        input  rf_write_data, rf_address, rf_read_en, rf_write_en
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter serialising NUM_CH request channels onto one RF handshake.
// Optional access abort after TIMEOUT_CYCLES is enabled by defining RF_TIMEOUT_EN.
module rf_access_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int HMC_RF_WWIDTH  = 64,
    parameter int HMC_RF_RWIDTH  = 64,
    parameter int HMC_RF_AWIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk_hmc,
    input logic                res_hmc,
    rf_access_arbiter_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = HMC_RF_AWIDTH;
    localparam int WW   = HMC_RF_WWIDTH;
    localparam int RW   = HMC_RF_RWIDTH;

    if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("rf_access_arbiter: NUM_CH must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [CH_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CH_W-1:0]   owner_q,   owner_d;
    logic              op_wr_q,   op_wr_d;
    logic [AW-1:0]     addr_q,    addr_d;
    logic [WW-1:0]     wdata_q,   wdata_d;
    logic [RW-1:0]     rdata_q,   rdata_d;
    logic [NUM_CH-1:0] grant_q,   grant_d;
    logic [NUM_CH-1:0] done_q,    done_d;
    logic              invalid_q, invalid_d;
    logic              rd_en_q,   rd_en_d;
    logic              wr_en_q,   wr_en_d;
    logic              busy_q,    busy_d;

`ifdef RF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    logic [NUM_CH-1:0] req;
    logic              req_any;
    logic [CH_W-1:0]   pick;
    logic              rsp_hit;

    // Scan from the furthest channel back toward rr_ptr+1 so the nearest requester wins.
    always_comb begin
        int idx;
        logic [CH_W-1:0] idx_c;
        idx     = 0;
        idx_c   = '0;
        req     = bus.ch_read_en | bus.ch_write_en;
        req_any = |req;
        pick    = rr_ptr_q;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CH_W'(idx);
            if (req[idx_c]) pick = idx_c;
        end
    end

    assign rsp_hit = bus.rf_access_complete | bus.rf_invalid_address;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        grant_d   = '0;
        done_d    = '0;
        invalid_d = invalid_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
`ifdef RF_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d[pick] = 1'b1;
                    rr_ptr_d      = pick;
                    owner_d       = pick;
                    op_wr_d       = bus.ch_write_en[pick];
                    addr_d        = bus.ch_address[int'(pick)*AW +: AW];
                    wdata_d       = bus.ch_write_data[int'(pick)*WW +: WW];
                    invalid_d     = 1'b0;
                    rd_en_d       = ~bus.ch_write_en[pick];
                    wr_en_d       = bus.ch_write_en[pick];
                    state_d       = ST_ACCESS;
`ifdef RF_TIMEOUT_EN
                    tmo_cnt_d     = '0;
                    timeout_d     = 1'b0;
`endif
                end
            end
            ST_ACCESS: begin
                if (rsp_hit) begin
                    rd_en_d         = 1'b0;
                    wr_en_d         = 1'b0;
                    done_d[owner_q] = 1'b1;
                    invalid_d       = bus.rf_invalid_address;
                    if (!bus.rf_invalid_address && !op_wr_q) rdata_d = bus.rf_read_data;
                    state_d         = ST_DONE;
                end
`ifdef RF_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rd_en_d         = 1'b0;
                    wr_en_d         = 1'b0;
                    done_d[owner_q] = 1'b1;
                    invalid_d       = 1'b0;
                    timeout_d       = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= CH_W'(NUM_CH - 1);
            owner_q   <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            invalid_q <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RF_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            invalid_q <= invalid_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
`ifdef RF_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.ch_grant      = grant_q;
    assign bus.ch_done       = done_q;
    assign bus.ch_read_data  = rdata_q;
    assign bus.ch_invalid    = invalid_q;
    assign bus.busy          = busy_q;
    assign bus.rf_address    = addr_q;
    assign bus.rf_write_data = wdata_q;
    assign bus.rf_read_en    = rd_en_q;
    assign bus.rf_write_en   = wr_en_q;
`ifdef RF_TIMEOUT_EN
    assign bus.ch_timeout    = timeout_q;
`else
    assign bus.ch_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed plus randomized bench for rf_access_arbiter against a round-robin reference model.
module tb_rf_access_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk_hmc = 1'b0;
    logic res_hmc = 1'b0;
    always #5 clk_hmc = ~clk_hmc;

    rf_access_arbiter_if #(.NUM_CH(N), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64),
                           .HMC_RF_AWIDTH(4)) bus ();

    rf_access_arbiter #(.NUM_CH(N), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64),
                        .HMC_RF_AWIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk_hmc (clk_hmc),
        .res_hmc (res_hmc),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    int          rr_m;
    logic [63:0] rdata_m;
    logic [3:0]  addr_m [N];
    logic [63:0] wd_m   [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int rr);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (rr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int ch, input logic rd, input logic wr,
                           input logic [3:0] a, input logic [63:0] d);
        addr_m[ch] = a;
        wd_m[ch]   = d;
        bus.ch_read_en[ch]            = rd;
        bus.ch_write_en[ch]           = wr;
        bus.ch_address[ch*4 +: 4]     = a;
        bus.ch_write_data[ch*64 +: 64] = d;
    endtask

    task automatic clear_inputs();
        bus.ch_read_en         = '0;
        bus.ch_write_en        = '0;
        bus.ch_address         = '0;
        bus.ch_write_data      = '0;
        bus.rf_read_data       = '0;
        bus.rf_invalid_address = 1'b0;
        bus.rf_access_complete = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        res_hmc = 1'b1;
        repeat (2) @(posedge clk_hmc);
        #1 res_hmc = 1'b0;
        rr_m    = N - 1;
        rdata_m = '0;
        @(posedge clk_hmc);
        #1;
    endtask

    // Wait for the grant the model predicts; returns the model's winner (or -1).
    task automatic wait_grant(output int w);
        logic [N-1:0] req;
        int n;
        req = bus.ch_read_en | bus.ch_write_en;
        w   = model_pick(req, rr_m);
        n   = 0;
        do begin
            @(posedge clk_hmc);
            #1 n++;
        end while (bus.ch_grant == '0 && n < 8);
        chk("grant", 64'(bus.ch_grant), (w < 0) ? 64'd0 : (64'd1 << w));
    endtask

    // kind: 0 = complete, 1 = invalid only, 2 = invalid+complete
    task automatic serve(input int dly, input int kind, input logic [63:0] rd);
        int w;
        logic is_wr;
        wait_grant(w);
        if (w < 0) return;
        is_wr = bus.ch_write_en[w];
        chk("rf_read_en",  64'(bus.rf_read_en),  64'(!is_wr));
        chk("rf_write_en", 64'(bus.rf_write_en), 64'(is_wr));
        chk("rf_address",  64'(bus.rf_address),  64'(addr_m[w]));
        chk("rf_wdata",    bus.rf_write_data,    wd_m[w]);
        chk("inv_cleared", 64'(bus.ch_invalid),  64'd0);
        chk("tmo_cleared", 64'(bus.ch_timeout),  64'd0);
        chk("busy_access", 64'(bus.busy),        64'd1);
        bus.ch_read_en[w]  = 1'b0;
        bus.ch_write_en[w] = 1'b0;
        repeat (dly) begin
            @(posedge clk_hmc);
            #1 chk("en_hold", 64'({bus.rf_read_en, bus.rf_write_en}), 64'({!is_wr, is_wr}));
        end
        bus.rf_access_complete = (kind != 1);
        bus.rf_invalid_address = (kind != 0);
        bus.rf_read_data       = rd;
        @(posedge clk_hmc);
        #1;
        bus.rf_access_complete = 1'b0;
        bus.rf_invalid_address = 1'b0;
        bus.rf_read_data       = {$urandom, $urandom};
        if (kind == 0 && !is_wr) rdata_m = rd;
        rr_m = w;
        chk("done",      64'(bus.ch_done),    64'd1 << w);
        chk("en_drop",   64'({bus.rf_read_en, bus.rf_write_en}), 64'd0);
        chk("invalid",   64'(bus.ch_invalid), 64'(kind != 0));
        chk("timeout",   64'(bus.ch_timeout), 64'd0);
        chk("read_data", bus.ch_read_data,    rdata_m);
        @(posedge clk_hmc);
        #1;
        chk("done_pulse", 64'(bus.ch_done), 64'd0);
        chk("busy_idle",  64'(bus.busy),    64'd0);
    endtask

    initial begin
        int w;
        int n;
        logic [N-1:0] pend;
        clear_inputs();
        do_reset();

        // Reset state
        chk("rst_outputs", {bus.ch_grant, bus.ch_done, 3'b0, bus.ch_invalid, bus.ch_timeout,
                            bus.busy, bus.rf_read_en, bus.rf_write_en, 4'h0, bus.rf_address,
                            40'h0}, 64'd0);
        chk("rst_rdata",  bus.ch_read_data,  64'd0);
        chk("rst_wdata",  bus.rf_write_data, 64'd0);

        // RF response outside ACCESS is ignored
        bus.rf_access_complete = 1'b1;
        bus.rf_read_data       = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk_hmc);
        #1;
        bus.rf_access_complete = 1'b0;
        chk("idle_rsp_busy",  64'(bus.busy),     64'd0);
        chk("idle_rsp_done",  64'(bus.ch_done),  64'd0);
        chk("idle_rsp_rdata", bus.ch_read_data,  64'd0);

        // ch1 read at 4'h3, RF completes after two enable cycles
        set_req(1, 1'b1, 1'b0, 4'h3, 64'h0);
        serve(1, 0, 64'hDEAD_BEEF);

        // All four write together: ch0..ch2, then ch3 beats a fresh ch0 request
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 4'(i + 8), {$urandom, $urandom});
        serve(0, 0, 64'h0);
        serve(2, 0, 64'h0);
        serve(1, 0, 64'h0);
        set_req(0, 1'b0, 1'b1, 4'h5, 64'hCAFE);
        serve(0, 0, 64'h0);
        serve(0, 0, 64'h0);

        // Read to establish data, then ch2 write to 4'hF answered invalid+complete
        set_req(1, 1'b1, 1'b0, 4'h2, 64'h0);
        serve(0, 0, 64'h0BAD_F00D_0000_0001);
        set_req(2, 1'b0, 1'b1, 4'hF, 64'h5555);
        serve(0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        // Invalid on a read keeps the old read data
        set_req(3, 1'b1, 1'b0, 4'hE, 64'h0);
        serve(1, 1, 64'h7777);

        // ch0 with both enables is a write
        set_req(0, 1'b1, 1'b1, 4'h4, 64'h1);
        serve(0, 0, 64'h0);

        // Randomized traffic: new requests join between services
        for (int it = 0; it < 40; it++) begin
            pend = bus.ch_read_en | bus.ch_write_en;
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    n = $urandom_range(0, 2);
                    set_req(c, n != 1, n != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
                end
            end
            if ((bus.ch_read_en | bus.ch_write_en) == '0)
                set_req($urandom_range(0, N - 1), 1'b1, 1'b0, 4'($urandom_range(0, 15)), 64'h0);
            serve($urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom});
        end
        n = 0;
        while ((bus.ch_read_en | bus.ch_write_en) != '0 && n < 8) begin
            serve($urandom_range(0, 2), 0, {$urandom, $urandom});
            n++;
        end

`ifdef RF_TIMEOUT_EN
        // Silent RF: abort after TO enable cycles, late response ignored
        set_req(3, 1'b1, 1'b0, 4'h9, 64'h0);
        wait_grant(w);
        bus.ch_read_en[3] = 1'b0;
        n = 1;
        do begin
            @(posedge clk_hmc);
            #1;
            if (bus.rf_read_en) n++;
        end while (bus.rf_read_en && n < 20);
        chk("tmo_en_cycles", 64'(n),              64'(TO));
        chk("tmo_done",      64'(bus.ch_done),    64'd1 << 3);
        chk("tmo_flag",      64'(bus.ch_timeout), 64'd1);
        chk("tmo_invalid",   64'(bus.ch_invalid), 64'd0);
        chk("tmo_rdata",     bus.ch_read_data,    rdata_m);
        rr_m = 3;
        bus.rf_access_complete = 1'b1;
        bus.rf_read_data       = 64'hABCD;
        repeat (2) @(posedge clk_hmc);
        #1;
        bus.rf_access_complete = 1'b0;
        chk("late_rsp_done",  64'(bus.ch_done),  64'd0);
        chk("late_rsp_busy",  64'(bus.busy),     64'd0);
        chk("late_rsp_rdata", bus.ch_read_data,  rdata_m);
        chk("tmo_sticky",     64'(bus.ch_timeout), 64'd1);
        // Next grant clears the flag
        set_req(2, 1'b1, 1'b0, 4'h1, 64'h0);
        serve(0, 0, 64'h4242);
        // Start an access to interrupt with reset
        set_req(1, 1'b0, 1'b1, 4'h6, 64'h99);
        wait_grant(w);
        bus.ch_write_en[1] = 1'b0;
`else
        // Silent RF with no timeout: access hangs
        set_req(3, 1'b1, 1'b0, 4'h9, 64'h0);
        wait_grant(w);
        bus.ch_read_en[3] = 1'b0;
        repeat (40) @(posedge clk_hmc);
        #1;
        chk("hang_busy",  64'(bus.busy),       64'd1);
        chk("hang_en",    64'(bus.rf_read_en), 64'd1);
        chk("hang_done",  64'(bus.ch_done),    64'd0);
`endif

        // Reset mid-access: enables drop at once, no completion, RR restarts at ch0
        @(posedge clk_hmc);
        #1 res_hmc = 1'b1;
        #1;
        chk("rst_mid_en",   64'({bus.rf_read_en, bus.rf_write_en}), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        n = 0;
        repeat (3) begin
            @(posedge clk_hmc);
            #1 if (bus.ch_done != '0) n++;
        end
        chk("rst_mid_nodone", 64'(n), 64'd0);
        res_hmc = 1'b0;
        clear_inputs();
        rr_m    = N - 1;
        rdata_m = '0;
        @(posedge clk_hmc);
        #1;
        set_req(0, 1'b1, 1'b0, 4'h0, 64'h0);
        set_req(3, 1'b0, 1'b1, 4'h3, 64'h33);
        serve(0, 0, 64'h1111);
        serve(1, 0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
